// File: rtl/handshake_cmpi_pkg.sv
// Shared definitions for the elastic integer comparator family: predicate
// codes and the predicate evaluation function.
package handshake_cmpi_pkg;

    localparam logic [3:0] CMPI_EQ  = 4'd0;
    localparam logic [3:0] CMPI_NE  = 4'd1;
    localparam logic [3:0] CMPI_SLT = 4'd2;
    localparam logic [3:0] CMPI_SLE = 4'd3;
    localparam logic [3:0] CMPI_SGT = 4'd4;
    localparam logic [3:0] CMPI_SGE = 4'd5;
    localparam logic [3:0] CMPI_ULT = 4'd6;
    localparam logic [3:0] CMPI_ULE = 4'd7;
    localparam logic [3:0] CMPI_UGT = 4'd8;
    localparam logic [3:0] CMPI_UGE = 4'd9;

    // Widest operand the evaluation function handles; narrower operands are
    // zero-extended into this container by the caller.
    localparam int CMPI_MAX_W = 64;

    typedef logic [CMPI_MAX_W-1:0] cmpi_word_t;

    // Evaluate one predicate on zero-extended operands of the given width.
    // Signed order is obtained by flipping the operand sign bit (bit width-1)
    // and comparing unsigned: this maps two's complement onto offset binary.
    function automatic logic cmpi_eval(
        input logic [3:0] pred,
        input cmpi_word_t a,
        input cmpi_word_t b,
        input int         width
    );
        cmpi_word_t sign_bit;
        cmpi_word_t a_s;
        cmpi_word_t b_s;
        logic       eq;
        logic       ult;
        logic       slt;
        logic       res;
        sign_bit = cmpi_word_t'(1) << (width - 1);
        a_s      = a ^ sign_bit;
        b_s      = b ^ sign_bit;
        eq       = (a == b);
        ult      = (a < b);
        slt      = (a_s < b_s);
        case (pred)
            CMPI_EQ:  res = eq;
            CMPI_NE:  res = ~eq;
            CMPI_SLT: res = slt;
            CMPI_SLE: res = slt | eq;
            CMPI_SGT: res = ~(slt | eq);
            CMPI_SGE: res = ~slt;
            CMPI_ULT: res = ult;
            CMPI_ULE: res = ult | eq;
            CMPI_UGT: res = ~(ult | eq);
            CMPI_UGE: res = ~ult;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/handshake_cmpi_pipelined_elastic_reg.sv
// Single elastic register slot: holds one token, accepts a new token in the
// same cycle its current token is taken downstream (full throughput).
// Handshake: a token moves across an interface on a rising clock edge where
// valid and ready are both high; valid never depends on ready.
module handshake_elastic_reg #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Slot is free, or its token leaves this cycle.
    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Token slot: load on accept, clear asynchronously on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/handshake_cmpi_pipelined.sv
// Elastic integer comparator: joins lhs and rhs tokens, evaluates one fixed
// predicate and sends the 1-bit result through LATENCY elastic stages.
// Handshake: a token moves across an interface on a rising clock edge where
// valid and ready are both high; valid never depends on ready, ready may
// depend combinationally on valid and on downstream ready.
module handshake_cmpi_pipelined
    import handshake_cmpi_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int PREDICATE = 2,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    output logic                 result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam logic [3:0] PRED_CODE = 4'(PREDICATE);

    if (PREDICATE < 0 || PREDICATE > 9) begin : g_bad_predicate
        $error("handshake_cmpi_pipelined: PREDICATE must be 0..9");
    end
    if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
        $error("handshake_cmpi_pipelined: LATENCY must be 0..4");
    end
    if (DATA_TYPE < 1 || DATA_TYPE > CMPI_MAX_W) begin : g_bad_width
        $error("handshake_cmpi_pipelined: DATA_TYPE out of range");
    end

    // Stage k input sits at index k, output of the last stage at LATENCY.
    logic [LATENCY:0] w_stage_valid;
    logic [LATENCY:0] w_stage_data;
    logic [LATENCY:0] w_stage_ready;
    logic             w_cmp;

    assign w_cmp = cmpi_eval(PRED_CODE, CMPI_MAX_W'(lhs), CMPI_MAX_W'(rhs), DATA_TYPE);

    // Join of two operands: the pair is offered to stage 0 only when both are
    // present, and each side is released only together with its partner.
    assign w_stage_valid[0] = lhs_valid & rhs_valid;
    assign w_stage_data[0]  = w_cmp;
    assign lhs_ready        = rhs_valid & w_stage_ready[0];
    assign rhs_ready        = lhs_valid & w_stage_ready[0];

    if (LATENCY == 0) begin : g_comb
        // No storage: the join hands the result straight to the consumer.
        // Reset masks the output token and blocks consumption.
        assign w_stage_ready[0] = result_ready & ~rst;
        assign result_valid     = w_stage_valid[0] & ~rst;
        assign result           = w_stage_data[0] & ~rst;
    end else begin : g_pipe
        assign w_stage_ready[LATENCY] = result_ready;
        for (genvar k = 0; k < LATENCY; k++) begin : g_stage
            handshake_elastic_reg #(
                .WIDTH(1)
            ) u_stage (
                .i_clk   (clk),
                .i_rst   (rst),
                .i_data  (w_stage_data[k +: 1]),
                .i_valid (w_stage_valid[k]),
                .o_ready (w_stage_ready[k]),
                .o_data  (w_stage_data[k+1 +: 1]),
                .o_valid (w_stage_valid[k+1]),
                .i_ready (w_stage_ready[k+1])
            );
        end
        assign result_valid = w_stage_valid[LATENCY];
        assign result       = w_stage_data[LATENCY];
    end

endmodule
